// File: rtl/pkg_teclado.sv
// Shared keypad definitions for the operand capture path.
//   KEY_ENTER / KEY_CLEAR : command key codes from the keypad decoder
//   KEY_DIG_MAX           : highest key code that is a decimal digit
//   estado_captura_t      : capture FSM states
package pkg_teclado;

  localparam logic [3:0] KEY_ENTER   = 4'hA;
  localparam logic [3:0] KEY_CLEAR   = 4'hC;
  localparam logic [3:0] KEY_DIG_MAX = 4'h9;

  typedef enum logic [1:0] {
    S_NUM1 = 2'd0,
    S_NUM2 = 2'd1,
    S_DONE = 2'd2
  } estado_captura_t;

endpackage

// File: rtl/module_acum_decimal.sv
// Decimal digit accumulator (combinational).
//   cur  : current operand value
//   d    : incoming decimal digit
//   next : low 8 bits of cur*10 + d
//   ovf  : cur*10 + d exceeds MAX_VAL, so the digit must be dropped
module module_acum_decimal #(
  parameter int MAX_VAL = 255
) (
  input  logic [7:0] cur,
  input  logic [3:0] d,
  output logic [7:0] next,
  output logic       ovf
);

  localparam logic [11:0] MAX_C = 12'(MAX_VAL);

  logic [11:0] cur_w;
  logic [11:0] cand;

  // 255*10 + 9 = 2559 fits in 12 bits, so the sum never wraps.
  assign cur_w = {4'b0000, cur};
  assign cand  = (cur_w << 3) + (cur_w << 1) + {8'b0000_0000, d};
  assign next  = cand[7:0];
  assign ovf   = (cand > MAX_C);

endmodule

// File: rtl/module_captura_operandos.sv
// Keypad operand capture: builds two decimal operands from key events and
// signals when each is confirmed, with a one-cycle multiplier start pulse.
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   key_valid : one-cycle strobe qualifying key_code
//   key_code  : 0-9 digit, A enter, C clear, others ignored
//   num_1     : first operand
//   num_2     : second operand
//   listo_1   : first operand confirmed
//   listo     : both operands confirmed
//   mul_start : one-cycle start pulse for the multiplier
module module_captura_operandos
  import pkg_teclado::*;
#(
  parameter int MAX_VAL = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [7:0] num_1,
  output logic [7:0] num_2,
  output logic       listo_1,
  output logic       listo,
  output logic       mul_start
);

  estado_captura_t state, state_nx;

  logic       key_dig, key_enter, key_clear;
  logic [7:0] acc_cur, acc_next;
  logic       acc_ovf;

  logic [7:0] num_1_nx, num_2_nx;
  logic       listo_1_nx, listo_nx, mul_start_nx;

  assign key_dig   = key_valid && (key_code <= KEY_DIG_MAX);
  assign key_enter = key_valid && (key_code == KEY_ENTER);
  assign key_clear = key_valid && (key_code == KEY_CLEAR);

  // One shared accumulator; the operand being edited is chosen by state.
  assign acc_cur = (state == S_NUM2) ? num_2 : num_1;

  module_acum_decimal #(
    .MAX_VAL(MAX_VAL)
  ) u_acum (
    .cur (acc_cur),
    .d   (key_code),
    .next(acc_next),
    .ovf (acc_ovf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_NUM1;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (key_clear) begin
      state_nx = S_NUM1;
    end else if (key_dig) begin
      if (state == S_DONE) state_nx = S_NUM1;
    end else if (key_enter) begin
      case (state)
        S_NUM1:  state_nx = S_NUM2;
        S_NUM2:  state_nx = S_DONE;
        S_DONE:  state_nx = S_DONE;
        default: state_nx = S_NUM1;
      endcase
    end else if (state != S_NUM1 && state != S_NUM2 && state != S_DONE) begin
      // Recover from the unused encoding.
      state_nx = S_NUM1;
    end
  end

  always_comb begin
    num_1_nx     = num_1;
    num_2_nx     = num_2;
    mul_start_nx = 1'b0;
    if (key_clear) begin
      num_1_nx = 8'd0;
      num_2_nx = 8'd0;
    end else if (key_dig) begin
      case (state)
        S_NUM1: if (!acc_ovf) num_1_nx = acc_next;
        S_NUM2: if (!acc_ovf) num_2_nx = acc_next;
        default: begin
          // A digit after completion starts a fresh operation.
          num_1_nx = {4'b0000, key_code};
          num_2_nx = 8'd0;
        end
      endcase
    end else if (key_enter && state == S_NUM2) begin
      mul_start_nx = 1'b1;
    end
    // Flags are registered copies of the next state so they track it exactly.
    listo_1_nx = (state_nx == S_NUM2) || (state_nx == S_DONE);
    listo_nx   = (state_nx == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_1     <= 8'd0;
      num_2     <= 8'd0;
      listo_1   <= 1'b0;
      listo     <= 1'b0;
      mul_start <= 1'b0;
    end else begin
      num_1     <= num_1_nx;
      num_2     <= num_2_nx;
      listo_1   <= listo_1_nx;
      listo     <= listo_nx;
      mul_start <= mul_start_nx;
    end
  end

endmodule

// File: tb/tb_module_captura_operandos.sv
// Bench for module_captura_operandos: directed key sequences followed by
// random keys, all checked against a value-level reference model.
module tb_module_captura_operandos;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [7:0] num_1, num_2;
  logic       listo_1, listo, mul_start;

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 = typing first, 1 = typing second, 2 = complete.
  int m_n1 = 0, m_n2 = 0, m_phase = 0, m_ms = 0;

  always #5 clk = ~clk;

  module_captura_operandos #(.MAX_VAL(255)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_valid(key_valid),
    .key_code (key_code),
    .num_1    (num_1),
    .num_2    (num_2),
    .listo_1  (listo_1),
    .listo    (listo),
    .mul_start(mul_start)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".num_1"}, int'(num_1), m_n1);
    chk({tag, ".num_2"}, int'(num_2), m_n2);
    chk({tag, ".listo_1"}, int'(listo_1), (m_phase != 0) ? 1 : 0);
    chk({tag, ".listo"}, int'(listo), (m_phase == 2) ? 1 : 0);
    chk({tag, ".mul_start"}, int'(mul_start), m_ms);
  endtask

  task automatic model_key(input int c);
    m_ms = 0;
    if (c == 12) begin
      m_n1 = 0; m_n2 = 0; m_phase = 0;
    end else if (c <= 9) begin
      if (m_phase == 2) begin
        m_n1 = c; m_n2 = 0; m_phase = 0;
      end else if (m_phase == 0) begin
        if (m_n1 * 10 + c <= 255) m_n1 = m_n1 * 10 + c;
      end else begin
        if (m_n2 * 10 + c <= 255) m_n2 = m_n2 * 10 + c;
      end
    end else if (c == 10) begin
      if (m_phase == 0) m_phase = 1;
      else if (m_phase == 1) begin
        m_phase = 2; m_ms = 1;
      end
    end
  endtask

  // Presents one key for one cycle; key_valid stays high so consecutive
  // calls form back-to-back pulses until idle() drops it.
  task automatic press(input int c, input string tag);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'(c);
    model_key(c);
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'($urandom_range(15));
    m_ms = 0;
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic model_reset();
    m_n1 = 0; m_n2 = 0; m_phase = 0; m_ms = 0;
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    @(negedge clk);
    rst = 1'b1;
    idle("post_reset");

    // 123 x 45
    press(1, "a1"); press(2, "a2"); press(3, "a3");
    press(10, "aA1"); press(4, "a4"); press(5, "a5");
    press(10, "aA2");
    idle("a_pulse_end");
    idle("a_hold");

    // Overflow drop, then 255 accepted
    press(12, "bC");
    press(2, "b2"); press(5, "b5"); press(6, "b6_drop");
    idle("b_hold");
    press(12, "bC2");
    press(2, "c2"); press(5, "c5"); press(5, "c5b");
    idle("c_hold");

    // Empty second operand, then enter in done state
    press(12, "dC");
    press(7, "d7"); press(10, "dA1"); press(10, "dA2");
    idle("d_idle");
    press(10, "dA3_ignored");
    idle("d_idle2");

    // 12 x 34, then a digit starts fresh, then clear
    press(12, "eC");
    press(1, "e1"); press(2, "e2"); press(10, "eA1");
    press(3, "e3"); press(4, "e4"); press(10, "eA2");
    press(9, "e9_new");
    press(12, "eC2");
    idle("e_idle");

    // Ignored codes interleaved with back-to-back digits
    press(11, "fB"); press(5, "f5"); press(13, "fD");
    press(0, "f0"); press(15, "fF"); press(14, "fE");
    idle("f_idle");

    // Asynchronous reset mid-entry
    press(12, "gC");
    press(4, "g4"); press(2, "g2"); press(10, "gA");
    press(7, "g7");
    idle("g_idle");
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk_all("async_reset");
    @(negedge clk);
    rst = 1'b1;
    idle("g_release");
    press(3, "g3");
    idle("g_idle2");

    // Random keys: digit-heavy mix with occasional gaps
    for (int i = 0; i < 400; i++) begin
      int r;
      int c;
      r = int'($urandom_range(99));
      if (r < 60)      c = int'($urandom_range(9));
      else if (r < 78) c = 10;
      else if (r < 83) c = 12;
      else             c = int'($urandom_range(15));
      press(c, "rnd");
      if ($urandom_range(3) == 0) idle("rnd_idle");
    end
    idle("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/module_captura_operandos.md
# module_captura_operandos

Keypad-side producer of the operand/ready interface consumed by the display priority selector and the multiplier. It receives decoded key events, builds two unsigned 8-bit decimal operands digit by digit, and raises `listo_1` once the first operand is confirmed and `listo` once the second is confirmed. It also issues a one-cycle `mul_start` pulse to the multiplier. It sits between the keypad scanner/debouncer and the display/multiplier path.

## Interface
Parameters:
- `MAX_VAL`, default 255: largest accepted operand value; must be ≤ 255.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `key_valid`  in  1  one-cycle pulse; `key_code` is valid in that cycle.
- `key_code`  in  4  decoded key:
  - 0x0–0x9: digit
  - 0xA: enter
  - 0xC: clear
  - 0xB, 0xD–0xF: ignored
- `num_1`  out  8  first operand, binary.
- `num_2`  out  8  second operand, binary.
- `listo_1`  out  1  first operand confirmed.
- `listo`  out  1  both operands confirmed.
- `mul_start`  out  1  one-cycle start pulse to the multiplier.

## Operation
- States: `S_NUM1`, `S_NUM2`, `S_DONE`.
- Reset state: `S_NUM1`.
- Reset value of every output is 0.
- Keys are acted on only in cycles where `key_valid`=1. All other cycles hold state, except `mul_start`, which returns to 0.
- Digit d, in `S_NUM1` or `S_NUM2`:
  - Compute cand = cur*10 + d, 12 bits wide.
  - If cand ≤ `MAX_VAL`: cur ← cand[7:0].
  - Otherwise the digit is dropped and cur is unchanged (no wrap, no saturation).
  - cur is `num_1` in `S_NUM1` and `num_2` in `S_NUM2`.
- Enter:
  - In `S_NUM1`: go to `S_NUM2`, `listo_1` ← 1.
  - In `S_NUM2`: go to `S_DONE`, `listo` ← 1, `mul_start` ← 1 for exactly one cycle.
  - Enter with no digits typed confirms the value 0.
- Enter in `S_DONE`: ignored. No second `mul_start`.
- Digit in `S_DONE`: starts a new operation.
  - `num_1` ← d, `num_2` ← 0.
  - `listo_1` ← 0, `listo` ← 0.
  - State ← `S_NUM1`.
- Clear, in any state: `num_1`, `num_2`, `listo_1` and `listo` ← 0; state ← `S_NUM1`.
- Ignored codes: no effect in any state.
- Output invariants:
  - `listo_1` is 1 exactly in `S_NUM2` and `S_DONE`.
  - `listo` is 1 exactly in `S_DONE`.
  - `num_2` is 0 whenever the state is `S_NUM1`.

## Timing
- All outputs are registered. A key accepted at edge k is visible after edge k (1-cycle latency).
- `mul_start` rises on the same edge as `listo`, and falls on the next edge.
- Back-to-back `key_valid` pulses on consecutive cycles must each be processed. No lost keys; no internal buffering beyond the current cycle.
- Asserting `rst` mid-entry clears all outputs immediately, without waiting for a clock edge. Release is synchronous to the system reset synchronizer, which is outside this block.
- If `rst` deasserts in the same cycle as a `key_valid` pulse, the key may be lost; the keypad source must not depend on it being captured.

## Structure
- Package `pkg_teclado` holds:
  - key code localparams: `KEY_ENTER`=4'hA, `KEY_CLEAR`=4'hC, digit range limit 4'h9;
  - typedef enum logic [1:0] `estado_captura_t` {`S_NUM1`, `S_NUM2`, `S_DONE`}.
- Sub-module `module_acum_decimal`: combinational.
  - Inputs: cur[7:0], d[3:0].
  - Outputs: next[7:0], ovf.
  - Computes cur*10 + d using shifts and adds ((cur<<3)+(cur<<1)+d) and flags ovf when the result > `MAX_VAL`.
  - Instantiated once, fed by a mux on the state.
- The top module holds the FSM, the operand registers and the pulse generation.

## Test plan
- Keys 1,2,3,A,4,5,A → `num_1`=123; `listo_1` rises after the first A; `num_2`=45; `listo`=1; `mul_start` high for exactly one cycle, coincident with `listo` rising.
- Keys 2,5,6 → `num_1` stays 25; the 6 is dropped (256 > 255). Then 2,5,5 from a fresh clear → `num_1`=255.
- Keys 7,A,A → `num_2`=0, `listo`=1. A further A in `S_DONE` → no `mul_start`, outputs unchanged.
- From `S_DONE` with 12×34: key 9 → `num_1`=9, `num_2`=0, `listo_1`=0, `listo`=0. Then key C → all outputs 0.
- Keys 5 then 0 on consecutive cycles, plus codes B/D/F interleaved → `num_1`=50; ignored codes change nothing.
- Assert `rst` low mid-entry (`num_1`=42, in `S_NUM2`) → all outputs 0 before the next clock edge; after release, key 3 → `num_1`=3.
